// File: rtl/side_ch_counter_sampler.sv
// side_ch_counter_sampler
// Snapshots six free-running side-channel event counters, either periodically
// or on a software pulse, and streams one record of per-counter deltas (each
// relative to the previous snapshot) over a valid/ready stream master.
// Optional build macro SIDE_CH_SAMPLER_TIMESTAMP_EN prepends a 32-bit
// cycle-count timestamp word to every record.
module side_ch_counter_sampler #(
  parameter int COUNTER_WIDTH = 16,
  parameter int PERIOD_WIDTH  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_en,
  input  logic [PERIOD_WIDTH-1:0]  period_cfg,
  input  logic                     sample_now,
  input  logic [COUNTER_WIDTH-1:0] counter0,
  input  logic [COUNTER_WIDTH-1:0] counter1,
  input  logic [COUNTER_WIDTH-1:0] counter2,
  input  logic [COUNTER_WIDTH-1:0] counter3,
  input  logic [COUNTER_WIDTH-1:0] counter4,
  input  logic [COUNTER_WIDTH-1:0] counter5,
  output logic [31:0]              m_tdata,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic                     m_tlast,
  output logic                     busy,
  input  logic                     overrun_clr,
  output logic [15:0]              overrun_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
`ifdef SIDE_CH_SAMPLER_TIMESTAMP_EN
  localparam logic [1:0] TS   = 2'd2;
`endif

  logic [1:0]               state;
  logic [2:0]               idx;
  logic [12:0]              seq;
  logic [PERIOD_WIDTH-1:0]  timer;
  logic                     tick;
  logic                     trigger;
  logic                     handshake;
  logic [COUNTER_WIDTH-1:0] counters [6];
  logic [COUNTER_WIDTH-1:0] prev     [6];
  logic [COUNTER_WIDTH-1:0] delta    [6];
  logic [COUNTER_WIDTH-1:0] delta_sel;
  logic [15:0]              delta_ext;
`ifdef SIDE_CH_SAMPLER_TIMESTAMP_EN
  logic [31:0]              ts_cnt;
  logic [31:0]              ts_latch;
`endif

  assign counters[0] = counter0;
  assign counters[1] = counter1;
  assign counters[2] = counter2;
  assign counters[3] = counter3;
  assign counters[4] = counter4;
  assign counters[5] = counter5;

  // The >= compare lets a lowered period_cfg fire on the very next cycle
  assign tick      = sample_en && (period_cfg != '0) &&
                     (timer >= (period_cfg - PERIOD_WIDTH'(1)));
  assign trigger   = sample_en && (tick || sample_now);
  assign handshake = m_tvalid && m_tready;
  assign m_tvalid  = (state != IDLE);
  assign busy      = (state != IDLE);

  // Period timer: counts while periodic sampling is active, otherwise parked at 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (sample_en && (period_cfg != '0)) begin
      timer <= tick ? '0 : timer + PERIOD_WIDTH'(1);
    end else begin
      timer <= '0;
    end
  end

`ifdef SIDE_CH_SAMPLER_TIMESTAMP_EN
  // Free-running timestamp, captured at the edge that accepts a trigger
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_cnt   <= '0;
      ts_latch <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      if (state == IDLE && trigger) begin
        ts_latch <= ts_cnt;
      end
    end
  end
`endif

  // Record sequencer: snapshot and delta on trigger, then walk the six words
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      seq   <= '0;
      for (int i = 0; i < 6; i++) begin
        prev[i]  <= '0;
        delta[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (trigger) begin
            for (int i = 0; i < 6; i++) begin
              delta[i] <= counters[i] - prev[i];
              prev[i]  <= counters[i];
            end
            idx <= '0;
`ifdef SIDE_CH_SAMPLER_TIMESTAMP_EN
            state <= TS;
`else
            state <= SEND;
`endif
          end
        end
`ifdef SIDE_CH_SAMPLER_TIMESTAMP_EN
        TS: begin
          if (handshake) begin
            state <= SEND;
          end
        end
`endif
        SEND: begin
          if (handshake) begin
            if (idx == 3'd5) begin
              idx   <= '0;
              seq   <= seq + 13'd1;
              state <= IDLE;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Overrun counter: triggers that arrive mid-record are dropped and counted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_cnt <= '0;
    end else if (overrun_clr) begin
      overrun_cnt <= '0;
    end else if (trigger && (state != IDLE) && (overrun_cnt != 16'hFFFF)) begin
      overrun_cnt <= overrun_cnt + 16'd1;
    end
  end

  // Output word mux: header fields plus the selected delta, zero-extended
  always_comb begin
    delta_sel = '0;
    case (idx)
      3'd0:    delta_sel = delta[0];
      3'd1:    delta_sel = delta[1];
      3'd2:    delta_sel = delta[2];
      3'd3:    delta_sel = delta[3];
      3'd4:    delta_sel = delta[4];
      3'd5:    delta_sel = delta[5];
      default: delta_sel = '0;
    endcase
    delta_ext = '0;
    delta_ext[COUNTER_WIDTH-1:0] = delta_sel;
    m_tdata = '0;
    m_tlast = 1'b0;
    case (state)
      SEND: begin
        m_tdata = {idx, seq, delta_ext};
        m_tlast = (idx == 3'd5);
      end
`ifdef SIDE_CH_SAMPLER_TIMESTAMP_EN
      TS: begin
        m_tdata = ts_latch;
      end
`endif
      default: begin
        m_tdata = '0;
        m_tlast = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_side_ch_counter_sampler.sv
// tb_side_ch_counter_sampler
// Directed scenarios for the counter sampler; expected stream words are queued
// when a trigger is issued and consumed by an independent stream monitor.
module tb_side_ch_counter_sampler;

  logic        clk;
  logic        rst;
  logic        sample_en;
  logic [31:0] period_cfg;
  logic        sample_now;
  logic [15:0] counter0, counter1, counter2, counter3, counter4, counter5;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic        busy;
  logic        overrun_clr;
  logic [15:0] overrun_cnt;

  int checks = 0;
  int errors = 0;
  int rec_count = 0;
  logic [32:0] sb [$];

  side_ch_counter_sampler #(.COUNTER_WIDTH(16), .PERIOD_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .period_cfg(period_cfg),
    .sample_now(sample_now),
    .counter0(counter0), .counter1(counter1), .counter2(counter2),
    .counter3(counter3), .counter4(counter4), .counter5(counter5),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .busy(busy),
    .overrun_clr(overrun_clr), .overrun_cnt(overrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // One-cycle software trigger; the accepting edge is the posedge inside
  task automatic applyStimulus();
    sample_now = 1'b1;
    stepCycle();
    sample_now = 1'b0;
  endtask

  function automatic logic [31:0] expWord(input int i, input logic [12:0] s,
                                          input logic [15:0] d);
    logic [2:0] i3;
    i3 = 3'(i);
    return {i3, s, d};
  endfunction

  task automatic pushWord(input int i, input logic [12:0] s, input logic [15:0] d);
    logic lst;
    lst = (i == 5);
    sb.push_back({lst, expWord(i, s, d)});
  endtask

  task automatic pushRecord(input logic [12:0] s,
                            input logic [15:0] d0, input logic [15:0] d1,
                            input logic [15:0] d2, input logic [15:0] d3,
                            input logic [15:0] d4, input logic [15:0] d5);
    pushWord(0, s, d0);
    pushWord(1, s, d1);
    pushWord(2, s, d2);
    pushWord(3, s, d3);
    pushWord(4, s, d4);
    pushWord(5, s, d5);
  endtask

  task automatic waitDrain(input int max_cycles);
    int n;
    n = 0;
    while (sb.size() != 0 && n < max_cycles) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkOutput("drain", 32'(sb.size()), 32'd0);
    stepCycle();
    stepCycle();
  endtask

  // Stream monitor: pop on handshake, check the held word while stalled
  always @(negedge clk) begin
    logic [32:0] e;
    if (!rst && m_tvalid) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_word", m_tdata, 32'hDEAD_BEEF);
      end else if (m_tready) begin
        e = sb.pop_front();
        checkOutput("word", m_tdata, e[31:0]);
        checkOutput("tlast", 32'(m_tlast), 32'(e[32]));
        if (m_tlast) rec_count++;
      end else begin
        e = sb[0];
        checkOutput("stall_hold", m_tdata, e[31:0]);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    int rec_before;
    rst = 1'b1;
    sample_en = 1'b0;
    period_cfg = '0;
    sample_now = 1'b0;
    m_tready = 1'b0;
    overrun_clr = 1'b0;
    {counter0, counter1, counter2, counter3, counter4, counter5} = '0;
    stepCycle();
    stepCycle();
    checkOutput("rst_tvalid", 32'(m_tvalid), 32'd0);
    checkOutput("rst_tlast", 32'(m_tlast), 32'd0);
    checkOutput("rst_tdata", m_tdata, 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_overrun", 32'(overrun_cnt), 32'd0);
    rst = 1'b0;
    stepCycle();

    $display("[TB] first record: deltas equal absolute values");
    sample_en = 1'b1;
    m_tready = 1'b1;
    counter0 = 16'd3; counter1 = 16'd5; counter5 = 16'hFFFF;
    pushRecord(13'd0, 16'd3, 16'd5, 16'd0, 16'd0, 16'd0, 16'hFFFF);
    applyStimulus();
    checkOutput("valid_after_trigger", 32'(m_tvalid), 32'd1);
    waitDrain(50);
    checkOutput("idle_after_rec1", 32'(busy), 32'd0);

    $display("[TB] second record: wrapped counter delta");
    counter0 = 16'd10; counter5 = 16'd4;
    pushRecord(13'd1, 16'd7, 16'd0, 16'd0, 16'd0, 16'd0, 16'd5);
    applyStimulus();
    waitDrain(50);
    checkOutput("overrun_after_rec2", 32'(overrun_cnt), 32'd0);

    $display("[TB] periodic sampling, period 100");
    for (int s = 2; s < 12; s++) begin
      pushRecord(13'(s), 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
    end
    rec_before = rec_count;
    period_cfg = 32'd100;
    n = 0;
    while (n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (m_tvalid) break;
    end
    checkOutput("first_periodic_valid", 32'(n), 32'd100);
    repeat (950) @(posedge clk);
    #1;
    period_cfg = '0;
    waitDrain(50);
    checkOutput("periodic_records", 32'(rec_count - rec_before), 32'd10);

    $display("[TB] toggling ready");
    counter1 = 16'd25; counter2 = 16'd7;
    pushRecord(13'd12, 16'd0, 16'd20, 16'd7, 16'd0, 16'd0, 16'd0);
    applyStimulus();
    n = 0;
    while (n < 40) begin
      m_tready = n[0];
      stepCycle();
      n++;
      if (!busy) break;
    end
    checkOutput("toggle_record_cycles", 32'(n), 32'd12);
    m_tready = 1'b1;
    waitDrain(20);

    $display("[TB] overrun while stalled");
    m_tready = 1'b0;
    counter3 = 16'd100;
    rec_before = rec_count;
    pushRecord(13'd13, 16'd0, 16'd0, 16'd0, 16'd100, 16'd0, 16'd0);
    applyStimulus();
    stepCycle();
    for (int k = 0; k < 3; k++) begin
      applyStimulus();
      stepCycle();
    end
    checkOutput("overrun_three", 32'(overrun_cnt), 32'd3);
    checkOutput("busy_stalled", 32'(busy), 32'd1);
    sample_now = 1'b1;
    overrun_clr = 1'b1;
    stepCycle();
    sample_now = 1'b0;
    overrun_clr = 1'b0;
    checkOutput("overrun_clr_priority", 32'(overrun_cnt), 32'd0);
    m_tready = 1'b1;
    waitDrain(30);
    repeat (10) stepCycle();
    checkOutput("single_record", 32'(rec_count - rec_before), 32'd1);

    $display("[TB] reset mid-record");
    counter4 = 16'd9;
    for (int i = 0; i < 4; i++) pushWord(i, 13'd14, 16'd0);
    applyStimulus();
    stepCycle();
    stepCycle();
    stepCycle();
    m_tready = 1'b0;
    stepCycle();
    checkOutput("mid_rec_valid", 32'(m_tvalid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort_tvalid", 32'(m_tvalid), 32'd0);
    checkOutput("abort_tlast", 32'(m_tlast), 32'd0);
    checkOutput("abort_tdata", m_tdata, 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    sb.delete();
    stepCycle();
    rst = 1'b0;
    stepCycle();
    m_tready = 1'b1;
    pushRecord(13'd0, 16'd10, 16'd25, 16'd7, 16'd100, 16'd9, 16'd4);
    applyStimulus();
    waitDrain(50);
    checkOutput("overrun_post_reset", 32'(overrun_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/side_ch_counter_sampler.md
Name: side_ch_counter_sampler

Overview:
- Downstream consumer of the side-channel event counters (counter0..counter5).
- Periodically, or on a software pulse, snapshots all six counters and computes a per-counter delta since the previous snapshot.
- Streams one 6-word record per snapshot over an AXI-Stream-style valid/ready master, for the side-channel DMA/FIFO path.
- Lets host software get event rates per interval without read-clear races on the counter registers.

Parameters:
COUNTER_WIDTH, 16, width of each input counter; legal range 1..16
PERIOD_WIDTH, 32, width of the sample-period register, in clk cycles

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
sample_en  input  1  master enable; 0 holds the period timer at 0 and ignores sample_now
period_cfg  input  PERIOD_WIDTH  sample interval in cycles; 0 disables periodic sampling
sample_now  input  1  single-cycle software trigger
counter0..counter5  input  COUNTER_WIDTH each  free-running event counters from upstream
m_tdata  output  32  record word
m_tvalid  output  1  word valid
m_tready  input  1  downstream ready
m_tlast  output  1  high on the final word of a record
busy  output  1  record in flight (state != IDLE)
overrun_clr  input  1  synchronous clear of overrun_cnt
overrun_cnt  output  16  count of dropped triggers, saturating

Behaviour:
- Reset (async assert): state=IDLE; m_tvalid=0, m_tlast=0, m_tdata=0, busy=0; overrun_cnt=0; period timer=0; seq=0; all prev and delta registers=0.
- Period timer:
  - Increments each cycle while sample_en=1 and period_cfg!=0.
  - When timer >= period_cfg-1: one-cycle tick, timer returns to 0. The >= compare means lowering period_cfg mid-interval fires on the next cycle.
- Trigger = sample_en & (tick | sample_now). Tick and sample_now in the same cycle count as one trigger.
- States: IDLE, SEND (optional TS before SEND, see below).
- IDLE with trigger at edge t:
  - delta_i <= (counter_i - prev_i) mod 2^COUNTER_WIDTH.
  - prev_i <= counter_i.
  - idx <= 0; state -> SEND.
  - m_tvalid is high from cycle t+1.
- SEND: m_tdata = {idx[2:0], seq[12:0], delta_idx zero-extended to 16}.
  - Word is held stable while m_tvalid & !m_tready.
  - On handshake: idx++.
  - m_tlast=1 when idx=5. Handshake on the last word: seq++ (13-bit wrap, 8191->0), state -> IDLE, m_tvalid=0 next cycle.
  - Minimum record spacing: 7 cycles (trigger, 6 words). A trigger is accepted in the cycle after the return to IDLE.
- Trigger while state != IDLE: dropped, no snapshot; overrun_cnt++ saturating at 65535.
  - overrun_clr has priority over increment in the same cycle.
- First record after reset: prev=0, so each delta equals the absolute counter value.
- Upstream counter cleared between snapshots: delta wraps modulo 2^COUNTER_WIDTH. No special handling; the host detects it.
- sample_en dropping mid-record: the current record completes; only new triggers are blocked.
- rst mid-record: immediate abort, outputs to reset values, no partial tlast.

Optional Feature:
- Macro: SIDE_CH_SAMPLER_TIMESTAMP_EN.
- Defined:
  - Adds a 32-bit free-running cycle counter, reset to 0, wrapping.
  - Its value is latched at the trigger edge.
  - State TS sits between IDLE and SEND and emits one header word = latched timestamp. TS is entered on trigger, left on handshake.
  - Record is 7 words; m_tlast on the 7th; minimum spacing 8 cycles.
- Undefined: no timestamp counter or TS state; record is 6 words.

Test Plan:
- Reset, sample_en=1, period_cfg=0, counters=3,5,0,0,0,65535, pulse sample_now, m_tready=1 -> words 0x0000_0003, 0x2000_0005, 0x4000_0000, 0x6000_0000, 0x8000_0000, 0xA000_FFFF; tlast on the last word; seq becomes 1.
- Next sample_now with counter0=10, counter5=4 (wrapped) -> idx0 delta 7, idx5 delta 5, seq field 1 (e.g. word0 = 0x0001_0007).
- period_cfg=100, sample_en=1, m_tready=1, 1000 cycles -> exactly 10 records, first m_tvalid at cycle 100 after enable.
- m_tready toggled 0/1 each cycle -> each word held stable while stalled, 6 words in order, record done in 12 cycles.
- sample_now pulsed 3 times during a record stalled by m_tready=0 -> overrun_cnt=3, single record; overrun_clr -> 0.
- Assert rst while idx=3 with m_tvalid=1 -> m_tvalid=0 immediately; after release, first record's deltas equal absolute counter values and seq=0.
